// File: rtl/biu_mem_responder.sv
// biu_mem_responder: responder side of the fetch/data request handshake.
// Latches one request, runs a single-word access on the memory port, and
// returns read data with a data_valid pulse or reports a timeout on bus_err.
// Optional one-word instruction prefetch buffer: define BIU_PREFETCH_EN.
module biu_mem_responder #(
  parameter int WAIT_MAX = 15,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_biu,
  input  logic [1:0]        sel_biu,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready_biu,
  output logic [DATA_W-1:0] bus,
  output logic              data_valid,
  output logic              bus_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  localparam logic [1:0] OP_FETCH = 2'b11;
  localparam logic [1:0] OP_WR    = 2'b01;

`ifdef BIU_PREFETCH_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DONE, S_ERR, S_PF} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;
`endif

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              accept;

`ifdef BIU_PREFETCH_EN
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [DATA_W-1:0] pf_data_q, pf_data_d;
  logic              pf_valid_q, pf_valid_d;
  logic              pf_pend_q, pf_pend_d;   // prefetch owed once IDLE is free
  logic [ADDR_W-1:0] pf_next_q, pf_next_d;   // address of the owed prefetch
`endif

  // Only a clean 1 on cs_biu counts; X/Z fall through to the no-accept branch.
  assign accept  = (state_q == S_IDLE) && (cs_biu == 1'b1) && (sel_biu != 2'b00);
  // Saturating wait counter increment.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Next-state, request latching and wait-counter logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
`ifdef BIU_PREFETCH_EN
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
    pf_pend_d  = pf_pend_q;
    pf_next_d  = pf_next_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = sel_biu;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = S_REQ;
`ifdef BIU_PREFETCH_EN
          // A new request supersedes any prefetch still owed.
          pf_pend_d = 1'b0;
          if (sel_biu == OP_FETCH && pf_valid_q && addr == pf_addr_q) begin
            bus_d     = pf_data_q;
            state_d   = S_DONE;
            pf_pend_d = 1'b1;
            pf_next_d = addr + ADDR_W'(1);
          end
          if (sel_biu == OP_WR && addr == pf_addr_q)
            pf_valid_d = 1'b0;
`endif
        end
`ifdef BIU_PREFETCH_EN
        else if (pf_pend_q) begin
          pf_addr_d  = pf_next_q;
          pf_valid_d = 1'b0;
          pf_pend_d  = 1'b0;
          cnt_d      = '0;
          state_d    = S_PF;
        end
`endif
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // Ack beats the timeout when both land on the same edge.
        if (mem_ack) begin
          if (op_q != OP_WR) bus_d = mem_rdata;
          state_d = S_DONE;
`ifdef BIU_PREFETCH_EN
          if (op_q == OP_FETCH) begin
            pf_pend_d = 1'b1;
            pf_next_d = addr_q + ADDR_W'(1);
          end
`endif
        end else if (cnt_inc == CNT_MAX) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
`ifdef BIU_PREFETCH_EN
      S_PF: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          pf_data_d  = mem_rdata;
          pf_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_inc == CNT_MAX) begin
          // Prefetch timeout is dropped quietly; buffer stays invalid.
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      bus_q   <= '0;
      cnt_q   <= '0;
`ifdef BIU_PREFETCH_EN
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
      pf_pend_q  <= 1'b0;
      pf_next_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bus_q   <= bus_d;
      cnt_q   <= cnt_d;
`ifdef BIU_PREFETCH_EN
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
      pf_pend_q  <= pf_pend_d;
      pf_next_q  <= pf_next_d;
`endif
    end
  end

  // Outputs decode directly from the registered state.
  assign ready_biu  = (state_q == S_IDLE) && !reset;
  assign bus        = bus_q;
  assign data_valid = (state_q == S_DONE) && op_q[1];
  assign bus_err    = (state_q == S_ERR);
  assign mem_wr     = (state_q == S_REQ) && (op_q == OP_WR);
  assign mem_wdata  = wdata_q;
`ifdef BIU_PREFETCH_EN
  assign mem_rd   = ((state_q == S_REQ) && op_q[1]) || (state_q == S_PF);
  assign mem_addr = (state_q == S_PF) ? pf_addr_q : addr_q;
`else
  assign mem_rd   = (state_q == S_REQ) && op_q[1];
  assign mem_addr = addr_q;
`endif

endmodule

// File: tb/tb_biu_mem_responder.sv
// Directed bench for biu_mem_responder with hand-computed expectations.
module tb_biu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_biu;
  logic [1:0]  sel_biu;
  logic [15:0] addr, wdata;
  logic        ready_biu, data_valid, bus_err, mem_rd, mem_wr, mem_ack;
  logic [15:0] bus, mem_addr, mem_wdata, mem_rdata;

  int errs   = 0;
  int checks = 0;

  biu_mem_responder #(.WAIT_MAX(15), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .cs_biu(cs_biu), .sel_biu(sel_biu),
    .addr(addr), .wdata(wdata), .ready_biu(ready_biu), .bus(bus),
    .data_valid(data_valid), .bus_err(bus_err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set afterwards are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] s, input logic [15:0] a, input logic [15:0] d);
    cs_biu = 1'b1; sel_biu = s; addr = a; wdata = d;
  endtask

  initial begin
    int n;
    reset = 1'b1; cs_biu = 1'b0; sel_biu = 2'b00; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ready", ready_biu, 0);
    chk("rst_bus", bus, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_rd_wr", {mem_rd, mem_wr}, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", ready_biu, 1);

    // Fetch read, ack on the second strobe cycle.
    req(2'b11, 16'h0010, 16'h0000);
    tick();
    chk("f_rd", mem_rd, 1);
    chk("f_maddr", mem_addr, 16'h0010);
    chk("f_ready", ready_biu, 0);
    cs_biu = 1'b0; sel_biu = 2'b00;
    tick();
    chk("f_rd2", mem_rd, 1);
    mem_ack = 1'b1; mem_rdata = 16'hA5C3;
    tick();
    mem_ack = 1'b0;
    chk("f_dv", data_valid, 1);
    chk("f_bus", bus, 16'hA5C3);
    chk("f_rd_off", mem_rd, 0);
    chk("f_ready_done", ready_biu, 0);
    tick();
    chk("f_dv_off", data_valid, 0);
    chk("f_ready_back", ready_biu, 1);

    // Data write with immediate ack.
    req(2'b01, 16'h0200, 16'h1234);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    chk("w_wr", mem_wr, 1);
    chk("w_rd", mem_rd, 0);
    chk("w_maddr", mem_addr, 16'h0200);
    chk("w_wdata", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("w_wr_off", mem_wr, 0);
    chk("w_dv", data_valid, 0);
    chk("w_bus_keep", bus, 16'hA5C3);
    tick();
    chk("w_ready", ready_biu, 1);

    // Timeout: no ack, strobe held exactly WAIT_MAX cycles.
    req(2'b10, 16'h0300, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      tick();
    end
    chk("to_rd_cycles", n, 15);
    chk("to_err", bus_err, 1);
    chk("to_dv", data_valid, 0);
    chk("to_bus_keep", bus, 16'hA5C3);
    tick();
    chk("to_err_off", bus_err, 0);
    chk("to_ready", ready_biu, 1);

    // Ack on the last allowed wait cycle wins over the timeout.
    req(2'b10, 16'h0301, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    for (int i = 0; i < 14; i++) tick();
    chk("late_rd", mem_rd, 1);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    chk("late_dv", data_valid, 1);
    chk("late_err", bus_err, 0);
    chk("late_bus", bus, 16'h5A5A);
    tick();
    chk("late_ready", ready_biu, 1);

    // Reset in the middle of a request.
    req(2'b11, 16'h0400, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    chk("mr_rd", mem_rd, 1);
    reset = 1'b1;
    tick();
    chk("mr_rd_off", mem_rd, 0);
    chk("mr_dv", data_valid, 0);
    chk("mr_ready_in_rst", ready_biu, 0);
    reset = 1'b0;
    tick();
    chk("mr_ready", ready_biu, 1);
    chk("mr_err", bus_err, 0);
    chk("mr_bus", bus, 16'h0000);

    // cs with sel=00 is ignored.
    req(2'b00, 16'h0777, 16'h0000);
    tick();
    chk("nop_strobes", {mem_rd, mem_wr}, 0);
    chk("nop_ready", ready_biu, 1);

    // Inputs changing during REQ do not disturb the latched request.
    req(2'b10, 16'h0555, 16'h0000);
    tick();
    req(2'b01, 16'h0AAA, 16'hFFFF);
    tick();
    chk("chg_maddr", mem_addr, 16'h0555);
    chk("chg_rdwr", {mem_rd, mem_wr}, 2'b10);
    chk("chg_wdata", mem_wdata, 16'h0000);
    cs_biu = 1'b0; sel_biu = 2'b00;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    chk("chg_dv", data_valid, 1);
    chk("chg_bus", bus, 16'h1111);
    tick();

    // cs held high: back-to-back accept on the first IDLE edge.
    req(2'b10, 16'h0600, 16'h0000);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    chk("b2b_dv", data_valid, 1);
    tick();
    chk("b2b_ready", ready_biu, 1);
    tick();
    chk("b2b_reaccept", mem_rd, 1);
    chk("b2b_maddr", mem_addr, 16'h0600);
    cs_biu = 1'b0; sel_biu = 2'b00;
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    chk("b2b_bus", bus, 16'h3333);
    tick();

`ifdef BIU_PREFETCH_EN
    // Fetch 0x0040, then observe prefetch of 0x0041.
    req(2'b11, 16'h0040, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    mem_ack = 1'b1; mem_rdata = 16'h4040;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("pf_rd", mem_rd, 1);
    chk("pf_maddr", mem_addr, 16'h0041);
    chk("pf_ready", ready_biu, 0);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("pf_err", bus_err, 0);
    chk("pf_idle", ready_biu, 1);
    // Hit on 0x0041.
    req(2'b11, 16'h0041, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    chk("hit_dv", data_valid, 1);
    chk("hit_rd", mem_rd, 0);
    chk("hit_bus", bus, 16'hBEEF);
    tick();
    tick();
    chk("pf2_maddr", mem_addr, 16'h0042);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    // Write to the prefetched address invalidates the buffer.
    req(2'b01, 16'h0042, 16'h9999);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    req(2'b11, 16'h0042, 16'h0000);
    tick();
    cs_biu = 1'b0; sel_biu = 2'b00;
    chk("inv_miss_rd", mem_rd, 1);
    chk("inv_miss_addr", mem_addr, 16'h0042);
    mem_ack = 1'b1; mem_rdata = 16'h4242;
    tick();
    mem_ack = 1'b0;
    chk("inv_bus", bus, 16'h4242);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
